tt_um_ajah_stott_holmes_serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor that succeeds the half adder as the team's next Tiny Tapeout user project. It uses a single full-adder cell, iterated over WIDTH clock cycles. Operands are shifted in a byte at a time over `ui_in`, and a start/busy/done handshake runs over `uio`. The result is read back byte-selectable on `uo_out`, and an accumulate mode chains operations. The block sits directly under the standard TT wrapper/testbench harness.

---
 rtl/tt_um_ajah_stott_holmes_serial_adder.sv | 149 ++++++++++++++
 tb/tb_tt_um_ajah_stott_holmes_serial_adder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_ajah_stott_holmes_serial_adder.sv
// Bit-serial adder/subtractor for Tiny Tapeout: byte-wide operand loading,
// one full-adder cell iterated over WIDTH cycles, byte-selectable readout.
module tt_um_ajah_stott_holmes_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [WIDTH-2:0]   sum_sh_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2:0]         ctl_q_reg;
  logic [2:0]         ctl_prev_reg;
  logic               c_reg;
  logic               sub_reg;
  logic               acc_reg;
  logic               carry_reg;
  logic               ovf_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [WIDTH-1:0]   a_next;
  logic [WIDTH-1:0]   b_next;
  logic [WIDTH-1:0]   sum_full;
  logic [2:0]         rise;
  logic               load_a_edge;
  logic               load_b_edge;
  logic               start_edge;
  logic               a_bit;
  logic               b_bit;
  logic               s_bit;
  logic               c_out;
  logic               last_bit;

  // Operands shift in MSB byte first, so each load pushes the old bytes up.
  generate
    if (WIDTH == 8) begin : g_load8
      assign a_next = ui_in;
      assign b_next = ui_in;
    end else begin : g_loadn
      assign a_next = {a_reg[WIDTH-9:0], ui_in};
      assign b_next = {b_reg[WIDTH-9:0], ui_in};
    end
  endgenerate

  assign rise        = ctl_q_reg & ~ctl_prev_reg;
  assign load_a_edge = rise[0];
  assign load_b_edge = rise[1];
  assign start_edge  = rise[2];

  // A and B are stable during RUN, so the counter indexes them directly.
  assign a_bit    = a_reg[cnt_reg];
  assign b_bit    = b_reg[cnt_reg] ^ sub_reg;
  assign s_bit    = a_bit ^ b_bit ^ c_reg;
  assign c_out    = (a_bit & b_bit) | (a_bit & c_reg) | (b_bit & c_reg);
  assign sum_full = {s_bit, sum_sh_reg};
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      result_reg   <= '0;
      sum_sh_reg   <= '0;
      cnt_reg      <= '0;
      ctl_q_reg    <= '0;
      ctl_prev_reg <= '0;
      c_reg        <= 1'b0;
      sub_reg      <= 1'b0;
      acc_reg      <= 1'b0;
      carry_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else if (ena) begin
      ctl_q_reg    <= uio_in[2:0];
      ctl_prev_reg <= ctl_q_reg;
      case (state_reg)
        IDLE, DONE: begin
          if (load_a_edge || load_b_edge) begin
            if (load_a_edge) a_reg <= a_next;
            if (load_b_edge) b_reg <= b_next;
            state_reg <= IDLE;
            done_reg  <= 1'b0;
          end else if (start_edge) begin
            sub_reg   <= uio_in[3];
            acc_reg   <= uio_in[4];
            c_reg     <= uio_in[3];
            cnt_reg   <= '0;
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        RUN: begin
          c_reg      <= c_out;
          sum_sh_reg <= sum_full[WIDTH-1:1];
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_bit) begin
            state_reg  <= DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            result_reg <= sum_full;
            carry_reg  <= c_out;
            // c_reg here is the carry into the MSB
            ovf_reg    <= c_reg ^ c_out;
            if (acc_reg) a_reg <= sum_full;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [7:0] byte_sel [4];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      if (gi < NBYTES) begin : g_valid
        assign byte_sel[gi] = result_reg[gi*8 +: 8];
      end else begin : g_zero
        assign byte_sel[gi] = 8'h00;
      end
    end
  endgenerate

  assign uo_out  = byte_sel[ui_in[1:0]];
  assign uio_out = {busy_reg, done_reg, carry_reg, ovf_reg, 4'b0000};
  assign uio_oe  = 8'hF0;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:5]};

endmodule

// File: tb/tb_tt_um_ajah_stott_holmes_serial_adder.sv
// Directed bench: an 8-bit and a 16-bit instance share stimulus; each test
// checks the instance it targets.
module tb_tt_um_ajah_stott_holmes_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo8, uio8, oe8, uo16, uio16, oe16;

  localparam logic [7:0] LA = 8'h01, LB = 8'h02, ST = 8'h04, SB = 8'h08, AC = 8'h10;

  int total = 0;
  int bad = 0;

  tt_um_ajah_stott_holmes_serial_adder #(.WIDTH(8)) dut8 (
    .ui_in(ui_in), .uo_out(uo8), .uio_in(uio_in), .uio_out(uio8),
    .uio_oe(oe8), .ena(ena), .clk(clk), .rst_n(rst_n));

  tt_um_ajah_stott_holmes_serial_adder #(.WIDTH(16)) dut16 (
    .ui_in(ui_in), .uo_out(uo16), .uio_in(uio_in), .uio_out(uio16),
    .uio_oe(oe16), .ena(ena), .clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         sub;
    logic [7:0] res;
    bit         carry;
    bit         ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] stat(input int w);
    return (w == 8) ? uio8 : uio16;
  endfunction

  task automatic do_reset;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic load(input logic [7:0] mask, input logic [7:0] d);
    ui_in  = d;
    uio_in = mask;
    tick;
    uio_in = 8'h00;
    tick;
  endtask

  task automatic start_op(input bit sub, input bit acc);
    logic [7:0] mode;
    mode   = (sub ? SB : 8'h00) | (acc ? AC : 8'h00);
    uio_in = ST | mode;
    tick;
    uio_in = mode;
    tick;
    uio_in = 8'h00;
  endtask

  task automatic wait_done(input int w, output int n);
    n = 0;
    while (stat(w)[7] && n < 200) begin
      n++;
      tick;
    end
  endtask

  task automatic rd(input int w, input logic [1:0] sel, output logic [7:0] v);
    ui_in = {6'b0, sel};
    #1;
    v = (w == 8) ? uo8 : uo16;
  endtask

  initial begin
    int n;
    logic [7:0] v;
    logic [7:0] st;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};

    // Reset state
    rst_n = 1'b0;
    #2;
    chk("reset_uo8", uo8, 8'h00);
    chk("reset_uio8", uio8, 8'h00);
    chk("reset_oe8", oe8, 8'hF0);
    chk("reset_uio16", uio16, 8'h00);
    do_reset;

    // Table-driven 8-bit add/sub
    foreach (vecs[i]) begin
      load(LA, vecs[i].a);
      load(LB, vecs[i].b);
      start_op(vecs[i].sub, 1'b0);
      wait_done(8, n);
      chk($sformatf("v%0d_busy_cycles", i), n, 8);
      st = stat(8);
      chk($sformatf("v%0d_done", i), st[6], 1);
      chk($sformatf("v%0d_carry", i), st[5], vecs[i].carry);
      chk($sformatf("v%0d_ovf", i), st[4], vecs[i].ovf);
      rd(8, 2'd0, v);
      chk($sformatf("v%0d_result", i), v, vecs[i].res);
    end
    rd(8, 2'd1, v);
    chk("w8_sel1_zero", v, 8'h00);

    // Accumulate: A += B three times
    do_reset;
    load(LA, 8'h01);
    load(LB, 8'h01);
    for (int k = 0; k < 3; k++) begin
      start_op(1'b0, 1'b1);
      chk($sformatf("acc%0d_busy", k), stat(8)[7], 1);
      wait_done(8, n);
      chk($sformatf("acc%0d_done", k), stat(8)[6], 1);
      rd(8, 2'd0, v);
      chk($sformatf("acc%0d_result", k), v, 8'h02 + k);
    end
    load(LB, 8'h00);
    chk("acc_load_clears_done", stat(8)[6], 0);
    start_op(1'b0, 1'b0);
    wait_done(8, n);
    rd(8, 2'd0, v);
    chk("acc_final_a", v, 8'h04);

    // 16-bit multi-byte load and readout
    do_reset;
    load(LA, 8'h12);
    load(LA, 8'h34);
    load(LB, 8'h0F);
    load(LB, 8'hFF);
    start_op(1'b0, 1'b0);
    wait_done(16, n);
    chk("w16_busy_cycles", n, 16);
    st = stat(16);
    chk("w16_done", st[6], 1);
    chk("w16_carry", st[5], 0);
    chk("w16_ovf", st[4], 0);
    rd(16, 2'd0, v);
    chk("w16_sel0", v, 8'h33);
    rd(16, 2'd1, v);
    chk("w16_sel1", v, 8'h22);
    rd(16, 2'd2, v);
    chk("w16_sel2", v, 8'h00);

    // Ignored pulses and ena freeze mid-RUN
    start_op(1'b0, 1'b0);
    chk("restart_busy", stat(16)[7], 1);
    chk("restart_done_drop", stat(16)[6], 0);
    n = 0;
    while (stat(16)[7] && n < 200) begin
      uio_in = (n == 2) ? (LA | ST) : 8'h00;
      ui_in  = (n == 2 || n == 3) ? 8'hAA : 8'h00;
      ena    = !(n >= 6 && n <= 10);
      n++;
      tick;
    end
    ena    = 1'b1;
    uio_in = 8'h00;
    chk("frozen_busy_cycles", n, 21);
    chk("frozen_done", stat(16)[6], 1);
    rd(16, 2'd0, v);
    chk("frozen_sel0", v, 8'h33);
    rd(16, 2'd1, v);
    chk("frozen_sel1", v, 8'h22);
    tick;
    start_op(1'b0, 1'b0);
    wait_done(16, n);
    rd(16, 2'd1, v);
    chk("a_unaffected_sel1", v, 8'h22);
    rd(16, 2'd0, v);
    chk("a_unaffected_sel0", v, 8'h33);

    // Reset in the middle of a run
    load(LA, 8'h44);
    start_op(1'b0, 1'b0);
    tick;
    tick;
    chk("prereset_busy", stat(16)[7], 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_uo16", uo16, 8'h00);
    chk("midrst_uio16", uio16, 8'h00);
    chk("midrst_oe16", oe16, 8'hF0);
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk("postrst_idle", stat(16)[7:6], 0);
    start_op(1'b0, 1'b0);
    wait_done(16, n);
    chk("postrst_busy_cycles", n, 16);
    rd(16, 2'd0, v);
    chk("postrst_sel0", v, 8'h00);
    rd(16, 2'd1, v);
    chk("postrst_sel1", v, 8'h00);
    chk("postrst_carry", stat(16)[5], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
